program_rom_arbiter: RTL and testbench

PROGRAM_ROM_ARBITER -- requirements
Module: program_rom_arbiter

---
 rtl/program_rom_arbiter_pkg.sv | 21 ++
 rtl/program_rom_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/program_rom_arbiter.sv | 68 ++++++
 tb/tb_program_rom_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/program_rom_arbiter_pkg.sv
// ============================================================================
// Module   : program_rom_arbiter_pkg
// Brief    : Shared types and width defaults for the program ROM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package program_rom_arbiter_pkg;

    localparam int c_ADDR_WIDTH = 14;
    localparam int c_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        GRANT_NONE   = 2'd0,
        GRANT_IFETCH = 2'd1,
        GRANT_DLOAD  = 2'd2
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/program_rom_arbiter_rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin arbiter, remembers the last granted port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
    import program_rom_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_req_ifetch,
    input  logic i_req_dload,
    output logic o_gnt_ifetch,
    output logic o_gnt_dload
);

    grant_t r_last_grant;
    logic   w_gnt_ifetch;
    logic   w_gnt_dload;

    // On a tie the port that did not win last time goes first; reset gates
    // both grants so nothing is accepted while the block is held in reset.
    assign w_gnt_ifetch = reset_n & i_req_ifetch &
                          (~i_req_dload | (r_last_grant == GRANT_DLOAD));
    assign w_gnt_dload  = reset_n & i_req_dload &
                          (~i_req_ifetch | (r_last_grant == GRANT_IFETCH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= GRANT_DLOAD;
        end else if (w_gnt_ifetch) begin
            r_last_grant <= GRANT_IFETCH;
        end else if (w_gnt_dload) begin
            r_last_grant <= GRANT_DLOAD;
        end
    end

    assign o_gnt_ifetch = w_gnt_ifetch;
    assign o_gnt_dload  = w_gnt_dload;

endmodule

`default_nettype wire

// File: rtl/program_rom_arbiter.sv
// ============================================================================
// Module   : program_rom_arbiter
// Brief    : Shares one synchronous program ROM between ifetch and dload.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_rom_arbiter
    import program_rom_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifetch_req,
    input  logic [ADDR_WIDTH-1:0] ifetch_addr,
    output logic                  ifetch_ready,
    output logic                  ifetch_rdata_valid,
    output logic [DATA_WIDTH-1:0] ifetch_rdata,
    input  logic                  dload_req,
    input  logic [ADDR_WIDTH-1:0] dload_addr,
    output logic                  dload_ready,
    output logic                  dload_rdata_valid,
    output logic [DATA_WIDTH-1:0] dload_rdata,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    logic   w_gnt_ifetch;
    logic   w_gnt_dload;
    grant_t r_resp_sel;

    rr_arbiter2 u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_req_ifetch (ifetch_req),
        .i_req_dload  (dload_req),
        .o_gnt_ifetch (w_gnt_ifetch),
        .o_gnt_dload  (w_gnt_dload)
    );

    assign ifetch_ready = w_gnt_ifetch;
    assign dload_ready  = w_gnt_dload;
    assign rom_addr     = w_gnt_dload ? dload_addr : ifetch_addr;

    // ROM data lands one cycle after its address, so the owner of that
    // read is simply whoever was granted in the previous cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_sel <= GRANT_NONE;
        end else if (w_gnt_ifetch) begin
            r_resp_sel <= GRANT_IFETCH;
        end else if (w_gnt_dload) begin
            r_resp_sel <= GRANT_DLOAD;
        end else begin
            r_resp_sel <= GRANT_NONE;
        end
    end

    assign ifetch_rdata_valid = (r_resp_sel == GRANT_IFETCH);
    assign dload_rdata_valid  = (r_resp_sel == GRANT_DLOAD);
    assign ifetch_rdata       = rom_q;
    assign dload_rdata        = rom_q;

endmodule

`default_nettype wire

// File: tb/tb_program_rom_arbiter.sv
// ============================================================================
// Module   : tb_program_rom_arbiter
// Brief    : Directed + random scoreboard bench for program_rom_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_rom_arbiter;

    localparam int c_AW = 14;
    localparam int c_DW = 32;
    localparam logic [1:0] c_P_NONE = 2'd0;
    localparam logic [1:0] c_P_I    = 2'd1;
    localparam logic [1:0] c_P_D    = 2'd2;

    typedef struct {
        logic [1:0]      port;
        logic [c_DW-1:0] data;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic            ifetch_req;
    logic [c_AW-1:0] ifetch_addr;
    logic            ifetch_ready;
    logic            ifetch_rdata_valid;
    logic [c_DW-1:0] ifetch_rdata;
    logic            dload_req;
    logic [c_AW-1:0] dload_addr;
    logic            dload_ready;
    logic            dload_rdata_valid;
    logic [c_DW-1:0] dload_rdata;
    logic [c_AW-1:0] rom_addr;
    logic [c_DW-1:0] rom_q;

    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    logic [1:0] m_last;
    int   i_wait;
    int   d_wait;
    logic obs_ri;
    logic obs_rd;

    program_rom_arbiter #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ifetch_req         (ifetch_req),
        .ifetch_addr        (ifetch_addr),
        .ifetch_ready       (ifetch_ready),
        .ifetch_rdata_valid (ifetch_rdata_valid),
        .ifetch_rdata       (ifetch_rdata),
        .dload_req          (dload_req),
        .dload_addr         (dload_addr),
        .dload_ready        (dload_ready),
        .dload_rdata_valid  (dload_rdata_valid),
        .dload_rdata        (dload_rdata),
        .rom_addr           (rom_addr),
        .rom_q              (rom_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: each word holds its own address.
    always @(posedge clk) rom_q <= {{(c_DW-c_AW){1'b0}}, rom_addr};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check previous response and this cycle's grant at the
    // falling edge, then advance past the rising edge.
    task automatic cycle(input logic ireq, input logic [c_AW-1:0] iaddr,
                         input logic dreq, input logic [c_AW-1:0] daddr);
        exp_t e;
        exp_t n;
        logic gi;
        logic gd;
        ifetch_req  = ireq;
        ifetch_addr = iaddr;
        dload_req   = dreq;
        dload_addr  = daddr;
        @(negedge clk);
        if (sb.size() != 0) e = sb.pop_front();
        else begin
            e.port = c_P_NONE;
            e.data = '0;
        end
        chk("ifetch_valid", 64'(ifetch_rdata_valid), 64'(e.port == c_P_I));
        chk("dload_valid", 64'(dload_rdata_valid), 64'(e.port == c_P_D));
        if (e.port == c_P_I) chk("ifetch_data", 64'(ifetch_rdata), 64'(e.data));
        if (e.port == c_P_D) chk("dload_data", 64'(dload_rdata), 64'(e.data));

        gi = ireq && (!dreq || m_last == c_P_D);
        gd = dreq && (!ireq || m_last == c_P_I);
        chk("ifetch_ready", 64'(ifetch_ready), 64'(gi));
        chk("dload_ready", 64'(dload_ready), 64'(gd));
        chk("rom_addr", 64'(rom_addr), 64'(gd ? daddr : iaddr));
        obs_ri = ifetch_ready;
        obs_rd = dload_ready;

        if (ireq && !ifetch_ready) i_wait++; else i_wait = 0;
        if (dreq && !dload_ready) d_wait++; else d_wait = 0;
        chk("ifetch_wait_le1", 64'(i_wait <= 1), 64'd1);
        chk("dload_wait_le1", 64'(d_wait <= 1), 64'd1);

        n.port = gi ? c_P_I : (gd ? c_P_D : c_P_NONE);
        n.data = {{(c_DW-c_AW){1'b0}}, (gd ? daddr : iaddr)};
        sb.push_back(n);
        if (gi) m_last = c_P_I;
        if (gd) m_last = c_P_D;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n    = 1'b0;
        ifetch_req = 1'b1;
        dload_req  = 1'b1;
        ifetch_addr = 14'h0155;
        #1;
        chk("rst_ifetch_ready", 64'(ifetch_ready), 64'd0);
        chk("rst_dload_ready", 64'(dload_ready), 64'd0);
        chk("rst_ifetch_valid", 64'(ifetch_rdata_valid), 64'd0);
        chk("rst_dload_valid", 64'(dload_rdata_valid), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'h0155);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        m_last = c_P_D;
        i_wait = 0;
        d_wait = 0;
    endtask

    initial begin
        logic            pi;
        logic            pd;
        logic [c_AW-1:0] ai;
        logic [c_AW-1:0] ad;
        n_cmp = 0;
        n_err = 0;
        m_last = c_P_D;
        i_wait = 0;
        d_wait = 0;
        obs_ri = 1'b0;
        obs_rd = 1'b0;
        reset_n = 1'b0;
        ifetch_req = 1'b0;
        dload_req = 1'b0;
        ifetch_addr = '0;
        dload_addr = '0;
        #2;
        reset_pulse();

        // Lone ifetch stream, back to back.
        cycle(1'b1, 14'h0010, 1'b0, 14'h0000);
        cycle(1'b1, 14'h0011, 1'b0, 14'h0000);
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);

        // Contention from reset: I, D, I, D.
        reset_pulse();
        for (int k = 0; k < 4; k++) cycle(1'b1, 14'h0100, 1'b1, 14'h2000);
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);

        // Lone dload at the top address.
        cycle(1'b0, 14'h0000, 1'b1, 14'h3FFF);
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);

        // last_grant holds across idle: lone ifetch, idle, then tie -> dload.
        cycle(1'b1, 14'h0042, 1'b0, 14'h0000);
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);
        cycle(1'b1, 14'h0043, 1'b1, 14'h1234);
        cycle(1'b1, 14'h0043, 1'b0, 14'h0000);
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);

        // Reset right after an ifetch accept drops its response.
        cycle(1'b1, 14'h0077, 1'b0, 14'h0000);
        reset_pulse();
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);
        cycle(1'b1, 14'h0200, 1'b1, 14'h0300);
        cycle(1'b0, 14'h0000, 1'b1, 14'h0300);
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);

        // Random traffic; a stalled requester keeps req and addr stable.
        pi = 1'b0; pd = 1'b0; ai = '0; ad = '0;
        for (int k = 0; k < 10000; k++) begin
            if (!(pi && !obs_ri)) begin
                pi = 1'($urandom_range(0, 1));
                ai = c_AW'($urandom);
            end
            if (!(pd && !obs_rd)) begin
                pd = 1'($urandom_range(0, 1));
                ad = c_AW'($urandom);
            end
            cycle(pi, ai, pd, ad);
        end
        cycle(1'b0, 14'h0000, 1'b0, 14'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
